modadd_rr_scheduler: RTL and testbench

//   Shares one multi-cycle modular add/sub core (start/done interface) among NREQ requesters.

---
 rtl/modadd_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/modadd_rr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_modadd_rr_scheduler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modadd_pkg.sv
// Shared types for the modular add/sub scheduler.
// Holds the default width, the op encoding and the scheduler FSM states.
package modadd_pkg;

    localparam int WIDTH_DEF = 256;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at/after i_ptr.
// Ports: i_req, i_ptr in; o_grant (one-hot), o_idx, o_any out.
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/modadd_rr_scheduler.sv
// Shares one start/done modular add/sub core among NREQ requesters.
// Ports: i_req_* request side, o_core_*/i_core_* core side,
//   o_rsp_*/i_rsp_ready response side, o_busy = FSM not idle.
// Define MODADD_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYC).
module modadd_rr_scheduler
    import modadd_pkg::*;
#(
    parameter int  NREQ        = 4,
    parameter int  WIDTH       = WIDTH_DEF,
    parameter int  TIMEOUT_CYC = 64,
    localparam int IW          = $clog2(NREQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NREQ-1:0]             i_req_valid,
    output logic [NREQ-1:0]             o_req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  i_req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  i_req_b,
    input  logic [NREQ-1:0]             i_req_op,
    input  logic [NREQ-1:0][WIDTH-1:0]  i_req_p,
    output logic                        o_core_start,
    output logic [WIDTH-1:0]            o_core_a,
    output logic [WIDTH-1:0]            o_core_b,
    output logic [WIDTH-1:0]            o_core_p,
    output logic                        o_core_op,
    input  logic [WIDTH-1:0]            i_core_result,
    input  logic                        i_core_done,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [WIDTH-1:0]            o_rsp_data,
    output logic [IW-1:0]               o_rsp_id,
    output logic                        o_rsp_err,
    output logic                        o_busy
);

    sched_state_e     r_state;
    logic [IW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    op_e              r_op;
    logic [IW-1:0]    r_id;
    logic [WIDTH-1:0] r_data;
    logic             r_start;
    logic             r_rsp_valid;
    logic             r_busy;

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;

`ifdef MODADD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ready is the accept strobe of the valid/ready handshake, so it is
    // decoded from the idle state in the same cycle; held low in reset.
    assign o_req_ready  = (r_state == IDLE && i_rst_n) ? w_grant : '0;
    assign o_core_start = r_start;
    assign o_core_a     = r_a;
    assign o_core_b     = r_b;
    assign o_core_p     = r_p;
    assign o_core_op    = r_op;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_data;
    assign o_rsp_id     = r_id;
    assign o_busy       = r_busy;

`ifdef MODADD_TIMEOUT_EN
    assign o_rsp_err = r_err;
`else
    // Watchdog compiled out: the error flag is a constant 0.
    assign o_rsp_err = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_op        <= OP_ADD;
            r_id        <= '0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MODADD_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= i_req_a[w_idx];
                        r_b     <= i_req_b[w_idx];
                        r_p     <= i_req_p[w_idx];
                        r_op    <= op_e'(i_req_op[w_idx]);
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == IW'(NREQ - 1)) ?
                                   '0 : w_idx + 1'b1;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
`ifdef MODADD_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                WAIT: begin
                    if (i_core_done) begin
                        r_data      <= i_core_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
`ifdef MODADD_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
`ifdef MODADD_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_data      <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modadd_rr_scheduler.sv
// Self-checking bench for modadd_rr_scheduler.
// Behavioural core with programmable latency plus a transaction-level model.
`timescale 1ns/1ps
module tb_modadd_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 256;
    localparam int IW   = 2;
    localparam int TO   = 64;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic [NREQ-1:0]        req_op;
    logic [NREQ-1:0][W-1:0] req_p;
    logic                   core_start;
    logic [W-1:0]           core_a;
    logic [W-1:0]           core_b;
    logic [W-1:0]           core_p;
    logic                   core_op;
    logic [W-1:0]           core_result;
    logic                   core_done_m;
    logic                   spur_done;
    logic                   core_done;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [W-1:0]           rsp_data;
    logic [IW-1:0]          rsp_id;
    logic                   rsp_err;
    logic                   busy;

    assign core_done = core_done_m | spur_done;

    modadd_rr_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .i_req_op      (req_op),
        .i_req_p       (req_p),
        .o_core_start  (core_start),
        .o_core_a      (core_a),
        .o_core_b      (core_b),
        .o_core_p      (core_p),
        .o_core_op     (core_op),
        .i_core_result (core_result),
        .i_core_done   (core_done),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_id      (rsp_id),
        .o_rsp_err     (rsp_err),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] p,
                                             input logic op);
        if (op) return (a + p - b) % p;
        return (a + b) % p;
    endfunction

    // Behavioural core: done L cycles after the start cycle.
    int           core_L    = 3;
    bit           core_hang = 1'b0;
    int           core_cnt  = 0;
    logic [W-1:0] core_res_q;

    initial begin
        core_done_m = 1'b0;
        core_result = '0;
        core_res_q  = '0;
    end

    always @(posedge clk) begin
        #1;
        core_done_m = 1'b0;
        core_result = {8{$urandom}};
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done_m = 1'b1;
                core_result = core_res_q;
            end
        end
        if (core_start && !core_hang) begin
            core_cnt   = core_L;
            core_res_q = ref_mod(core_a, core_b, core_p, core_op);
        end
    end

    // Transaction-level reference: one outstanding job, round-robin pick.
    bit           m_busy = 1'b0;
    bit           m_rsp  = 1'b0;
    bit           m_err  = 1'b0;
    int           m_t    = 0;
    int           m_ptr  = 0;
    int           m_id   = 0;
    logic [W-1:0] m_res  = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int              g;
        bit              es;
        bit              ev;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_rsp  = 1'b0;
            m_err  = 1'b0;
            m_ptr  = 0;
        end else begin
            er = '0;
            g  = -1;
            es = 1'b0;
            ev = 1'b0;
            if (m_busy) begin
                es = (cyc == m_t + 1);
                ev = m_rsp;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ])
                        g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) er[g] = 1'b1;
            chk("ready", W'(req_ready), W'(er));
            chk("start", W'(core_start), W'(es));
            chk("rsp_valid", W'(rsp_valid), W'(ev));
            chk("busy", W'(busy), W'(m_busy));
            if (ev) begin
                chk("rsp_data", rsp_data, m_err ? '0 : m_res);
                chk("rsp_id", W'(rsp_id), W'(m_id));
                chk("rsp_err", W'(rsp_err), W'(m_err));
            end
            if (m_busy) begin
                if (m_rsp) begin
                    if (rsp_ready) begin
                        m_busy = 1'b0;
                        m_rsp  = 1'b0;
                    end
                end else if (cyc >= m_t + 2) begin
                    if (core_done) begin
                        m_rsp = 1'b1;
                        m_err = 1'b0;
                    end
`ifdef MODADD_TIMEOUT_EN
                    else if (cyc == m_t + 2 + TO - 1) begin
                        m_rsp = 1'b1;
                        m_err = 1'b1;
                    end
`endif
                end
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_t    = cyc;
                m_id   = g;
                m_res  = ref_mod(req_a[g], req_b[g], req_p[g], req_op[g]);
                m_ptr  = (g + 1) % NREQ;
                m_err  = 1'b0;
            end
        end
    end

    task automatic txn(input int id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] p,
                       input logic op, input int hold,
                       output int t_acc, output int t_rsp,
                       output logic [W-1:0] d, output int rid,
                       output logic e, output int nst,
                       output int nunst, output bit ok);
        bit fin;
        fin   = 1'b0;
        t_acc = -1;
        t_rsp = -1;
        nst   = 0;
        nunst = 0;
        d     = '0;
        rid   = -1;
        e     = 1'b0;
        req_a[id]     = a;
        req_b[id]     = b;
        req_p[id]     = p;
        req_op[id]    = op;
        req_valid[id] = 1'b1;
        rsp_ready     = (hold == 0);
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            if (core_start) nst++;
            if (t_acc < 0 && req_ready[id]) t_acc = cyc;
            if (rsp_valid) begin
                if (t_rsp < 0) begin
                    t_rsp = cyc;
                    d     = rsp_data;
                    rid   = int'(rsp_id);
                    e     = rsp_err;
                end else if (rsp_data !== d || int'(rsp_id) != rid) begin
                    nunst++;
                end
                if (rsp_ready) fin = 1'b1;
            end
            @(posedge clk);
            #1;
            if (t_acc >= 0) req_valid[id] = 1'b0;
            if (t_rsp >= 0 && cyc >= t_rsp + hold) rsp_ready = 1'b1;
        end
        rsp_ready = 1'b0;
        ok = fin;
    endtask

    task automatic drain();
        bit              idle;
        logic [NREQ-1:0] rdy;
        idle      = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 500 && !idle; k++) begin
            @(negedge clk);
            rdy  = req_ready;
            idle = (req_valid == '0) && !busy;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~rdy;
        end
        chk("drain", W'(idle), W'(1));
        rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int           t_acc;
        int           t_rsp;
        int           rid;
        int           nst;
        int           nunst;
        bit           ok;
        logic         e;
        logic [W-1:0] d;
        int           order[$];
        int           exp_order[5];
        logic [NREQ-1:0] rdy;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_p     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        spur_done = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state, with requests pending to see ready stays low.
        rst_n     = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_start", W'(core_start), W'(0));
        chk("rst_ready", W'(req_ready), W'(0));
        chk("rst_core_a", core_a, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_err", W'(rsp_err), W'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // 5 + 7 mod 11 on req0, core latency 3.
        core_L = 3;
        txn(0, W'(5), W'(7), W'(11), 1'b0, 0,
            t_acc, t_rsp, d, rid, e, nst, nunst, ok);
        chk("t1_done", W'(ok), W'(1));
        chk("t1_latency", W'(t_rsp - t_acc), W'(5));
        chk("t1_starts", W'(nst), W'(1));
        chk("t1_data", d, W'(1));
        chk("t1_id", W'(rid), W'(0));
        chk("t1_err", W'(e), W'(0));

        // 3 - 5 mod 11 on req2, response back-pressured 4 cycles.
        txn(2, W'(3), W'(5), W'(11), 1'b1, 4,
            t_acc, t_rsp, d, rid, e, nst, nunst, ok);
        chk("t2_done", W'(ok), W'(1));
        chk("t2_data", d, W'(9));
        chk("t2_id", W'(rid), W'(2));
        chk("t2_stable", W'(nunst), W'(0));
        @(negedge clk);
        chk("t2_idle", W'(busy), W'(0));
        @(posedge clk);
        #1;

        // Done pulse with nothing outstanding must be dropped.
        pulse_reset();
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_rsp", W'(rsp_valid), W'(0));
            chk("spur_busy", W'(busy), W'(0));
        end
        @(posedge clk);
        #1;

        // All requesters valid: strict rotation from pointer 0.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i]  = W'(i + 1);
            req_b[i]  = W'(2 * i + 1);
            req_p[i]  = W'(13);
            req_op[i] = i[0];
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        core_L    = 2;
        for (int k = 0; k < 200 && order.size() < 5; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("rr_onehot", W'($countones(req_ready)), W'(1));
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) order.push_back(i);
            end
            @(posedge clk);
            #1;
        end
        chk("rr_count", W'(order.size()), W'(5));
        for (int i = 0; i < 5; i++)
            if (i < order.size())
                chk("rr_order", W'(order[i]), W'(exp_order[i]));
        req_valid = '0;
        drain();

        // Reset while waiting on the core.
        core_L       = 6;
        req_a[1]     = W'(4);
        req_b[1]     = W'(6);
        req_p[1]     = W'(7);
        req_op[1]    = 1'b0;
        req_valid[1] = 1'b1;
        t_acc        = -1;
        for (int k = 0; k < 50 && t_acc < 0; k++) begin
            @(negedge clk);
            if (req_ready[1]) t_acc = cyc;
            @(posedge clk);
            #1;
        end
        chk("rw_accept", W'(t_acc >= 0), W'(1));
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rw_busy_pre", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("rw_busy", W'(busy), W'(0));
        chk("rw_rsp_valid", W'(rsp_valid), W'(0));
        chk("rw_core_p", core_p, '0);
        chk("rw_rsp_data", rsp_data, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("rw_late_done", W'(rsp_valid), W'(0));
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        rdy          = '0;
        for (int k = 0; k < 20 && rdy == '0; k++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
        end
        chk("rw_next_grant", W'(rdy), W'(4'b0001));
        req_valid[0] = 1'b0;
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    int pi;
                    pi           = int'($urandom_range(1000, 2));
                    req_p[i]     = W'(pi);
                    req_a[i]     = W'($urandom_range(pi - 1, 0));
                    req_b[i]     = W'($urandom_range(pi - 1, 0));
                    req_op[i]    = 1'($urandom_range(1));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = 1'($urandom_range(1));
            core_L    = int'($urandom_range(5, 1));
            spur_done = !busy && ($urandom_range(7) == 0);
        end
        spur_done = 1'b0;
        drain();

`ifdef MODADD_TIMEOUT_EN
        // Core never answers: watchdog returns an error response.
        core_hang = 1'b1;
        txn(0, W'(5), W'(7), W'(11), 1'b0, 0,
            t_acc, t_rsp, d, rid, e, nst, nunst, ok);
        chk("to_done", W'(ok), W'(1));
        chk("to_latency", W'(t_rsp - t_acc), W'(2 + TO));
        chk("to_err", W'(e), W'(1));
        chk("to_data", d, '0);
        core_hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
